// File: rtl/cluster_pwr_seq_pkg.sv
// Shared types for the cluster power sequencer.
package cluster_pwr_seq_pkg;

   typedef enum logic [2:0] {
      OFF,
      PWR_UP,
      CLK_UP,
      ON,
      DRAIN,
      ISO,
      CLK_DN,
      PWR_DN
   } state_t;

endpackage

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: orders power, clock, reset and isolation on the way up
// and drains, isolates, gates the clock and removes power on the way down.
module cluster_pwr_seq
   import cluster_pwr_seq_pkg::*;
#(
   parameter int BOOT_ADDR_W    = 64,
   parameter int PWR_SETTLE_CYC = 16,
   parameter int RST_HOLD_CYC   = 8,
   parameter int CNT_W          = 8
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   test_mode_i,
   input  logic                   pwr_on_req_i,
   input  logic                   fetch_en_req_i,
   input  logic [BOOT_ADDR_W-1:0] boot_addr_i,
   input  logic                   cluster_busy_i,
   output logic                   cluster_pow_o,
   output logic                   cluster_byp_o,
   output logic                   cluster_clk_en_o,
   output logic                   cluster_iso_o,
   output logic                   cluster_rstn_o,
   output logic                   cluster_fetch_enable_o,
   output logic [BOOT_ADDR_W-1:0] cluster_boot_addr_o,
   output logic                   seq_done_o,
   output logic                   cluster_on_o
);

   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(PWR_SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(RST_HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

   // Outputs are set on the transition into each state, so every output is a
   // register reflecting the state just entered. In DRAIN the counter is reused
   // to count consecutive idle cycles.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state                  <= OFF;
         cnt                    <= '0;
         cluster_pow_o          <= 1'b0;
         cluster_byp_o          <= 1'b1;
         cluster_clk_en_o       <= 1'b0;
         cluster_iso_o          <= 1'b1;
         cluster_rstn_o         <= 1'b0;
         cluster_fetch_enable_o <= 1'b0;
         cluster_boot_addr_o    <= '0;
         seq_done_o             <= 1'b0;
         cluster_on_o           <= 1'b0;
      end else begin
         seq_done_o <= 1'b0;
         case (state)
            OFF: begin
               if (pwr_on_req_i) begin
                  state         <= PWR_UP;
                  cnt           <= SETTLE_LOAD;
                  cluster_pow_o <= 1'b1;
               end
            end
            PWR_UP: begin
               if (cnt == '0) begin
                  state            <= CLK_UP;
                  cnt              <= HOLD_LOAD;
                  cluster_clk_en_o <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            CLK_UP: begin
               if (cnt == '0) begin
                  state               <= ON;
                  cluster_rstn_o      <= 1'b1;
                  cluster_iso_o       <= 1'b0;
                  cluster_on_o        <= 1'b1;
                  seq_done_o          <= 1'b1;
                  cluster_byp_o       <= test_mode_i;
                  cluster_boot_addr_o <= boot_addr_i;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            ON: begin
               cluster_byp_o <= test_mode_i;
               if (!pwr_on_req_i) begin
                  state                  <= DRAIN;
                  cnt                    <= '0;
                  cluster_on_o           <= 1'b0;
                  cluster_fetch_enable_o <= 1'b0;
               end else begin
                  cluster_fetch_enable_o <= fetch_en_req_i;
               end
            end
            DRAIN: begin
               cluster_byp_o <= test_mode_i;
               if (cluster_busy_i) begin
                  cnt <= '0;
               end else if (cnt != '0) begin
                  state          <= ISO;
                  cnt            <= HOLD_LOAD;
                  cluster_iso_o  <= 1'b1;
                  cluster_rstn_o <= 1'b0;
               end else begin
                  cnt <= CNT_ONE;
               end
            end
            ISO: begin
               cluster_byp_o <= test_mode_i;
               if (cnt == '0) begin
                  state            <= CLK_DN;
                  cluster_clk_en_o <= 1'b0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            CLK_DN: begin
               state         <= PWR_DN;
               cnt           <= SETTLE_LOAD;
               cluster_pow_o <= 1'b0;
               cluster_byp_o <= 1'b1;
            end
            PWR_DN: begin
               if (cnt == '0) begin
                  state               <= OFF;
                  seq_done_o          <= 1'b1;
                  cluster_boot_addr_o <= '0;
               end else begin
                  cnt <= cnt - CNT_ONE;
               end
            end
            default: state <= OFF;
         endcase
      end
   end

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Self-checking bench for cluster_pwr_seq: directed vector table, hand-written
// corner sequences, then random stimulus against a phase/age reference model.
module tb_cluster_pwr_seq;

   localparam int S  = 16;
   localparam int H  = 8;
   localparam int AW = 64;

   localparam int UP_LEN   = S + H;
   localparam int DOWN_LEN = H + 1 + S;

   localparam int M_OFF   = 0;
   localparam int M_UP    = 1;
   localparam int M_ON    = 2;
   localparam int M_DRAIN = 3;
   localparam int M_DOWN  = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          test_mode;
   logic          pwr_on_req;
   logic          fetch_en_req;
   logic [AW-1:0] boot_addr;
   logic          cluster_busy;
   logic          cluster_pow;
   logic          cluster_byp;
   logic          cluster_clk_en;
   logic          cluster_iso;
   logic          cluster_rstn;
   logic          cluster_fetch_enable;
   logic [AW-1:0] cluster_boot_addr;
   logic          seq_done;
   logic          cluster_on;

   int total = 0;
   int bad   = 0;

   cluster_pwr_seq #(
      .BOOT_ADDR_W   (AW),
      .PWR_SETTLE_CYC(S),
      .RST_HOLD_CYC  (H),
      .CNT_W         (8)
   ) dut (
      .clk_i                 (clk),
      .rst_i                 (rst),
      .test_mode_i           (test_mode),
      .pwr_on_req_i          (pwr_on_req),
      .fetch_en_req_i        (fetch_en_req),
      .boot_addr_i           (boot_addr),
      .cluster_busy_i        (cluster_busy),
      .cluster_pow_o         (cluster_pow),
      .cluster_byp_o         (cluster_byp),
      .cluster_clk_en_o      (cluster_clk_en),
      .cluster_iso_o         (cluster_iso),
      .cluster_rstn_o        (cluster_rstn),
      .cluster_fetch_enable_o(cluster_fetch_enable),
      .cluster_boot_addr_o   (cluster_boot_addr),
      .seq_done_o            (seq_done),
      .cluster_on_o          (cluster_on)
   );

   always #5 clk = ~clk;

   // Reference model: coarse phase plus the number of edges spent in the up or
   // down sequence; individual outputs are derived from that age arithmetically.
   int            m_phase = M_OFF;
   int            m_age   = 0;
   int            m_idle  = 0;
   logic [AW-1:0] m_boot  = '0;
   logic          m_fetch = 1'b0;
   logic          m_done  = 1'b0;
   logic          m_tm    = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = M_OFF;
         m_age   = 0;
         m_idle  = 0;
         m_boot  = '0;
         m_fetch = 1'b0;
         m_done  = 1'b0;
         m_tm    = 1'b0;
      end else begin
         m_done = 1'b0;
         case (m_phase)
            M_OFF: if (pwr_on_req) begin m_phase = M_UP; m_age = 0; end
            M_UP: begin
               m_age++;
               if (m_age == UP_LEN) begin
                  m_phase = M_ON;
                  m_boot  = boot_addr;
                  m_done  = 1'b1;
               end
            end
            M_ON: begin
               if (!pwr_on_req) begin
                  m_phase = M_DRAIN;
                  m_idle  = 0;
                  m_fetch = 1'b0;
               end else begin
                  m_fetch = fetch_en_req;
               end
            end
            M_DRAIN: begin
               m_idle = cluster_busy ? 0 : m_idle + 1;
               if (m_idle == 2) begin m_phase = M_DOWN; m_age = 0; end
            end
            default: begin
               m_age++;
               if (m_age == DOWN_LEN) begin
                  m_phase = M_OFF;
                  m_done  = 1'b1;
                  m_boot  = '0;
               end
            end
         endcase
         m_tm = test_mode;
      end
   end

   typedef struct {
      int            cycles;
      logic          req, fen, busy, tm;
      logic [AW-1:0] boot_in;
      logic          pow, clk_en, iso, rstn, fetch, on, done, byp;
      logic [AW-1:0] boot_out;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int cycles, logic req, logic fen, logic busy, logic tm,
                               logic [AW-1:0] boot_in, logic pow, logic clk_en, logic iso,
                               logic rstn, logic fetch, logic on, logic done, logic byp,
                               logic [AW-1:0] boot_out);
      vec_t v;
      v.cycles = cycles; v.req = req; v.fen = fen; v.busy = busy; v.tm = tm;
      v.boot_in = boot_in; v.pow = pow; v.clk_en = clk_en; v.iso = iso; v.rstn = rstn;
      v.fetch = fetch; v.on = on; v.done = done; v.byp = byp; v.boot_out = boot_out;
      return v;
   endfunction

   task automatic check_bit(string name, logic act, logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0b required=%0b", name, act, exp);
      end
   endtask

   task automatic check_word(string name, logic [AW-1:0] act, logic [AW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(vec_t v);
      pwr_on_req   = v.req;
      fetch_en_req = v.fen;
      cluster_busy = v.busy;
      test_mode    = v.tm;
      boot_addr    = v.boot_in;
      repeat (v.cycles) tick();
   endtask

   task automatic check_output(vec_t v, int idx);
      string p;
      p = $sformatf("vec%0d", idx);
      check_bit({p, " pow"}, cluster_pow, v.pow);
      check_bit({p, " clk_en"}, cluster_clk_en, v.clk_en);
      check_bit({p, " iso"}, cluster_iso, v.iso);
      check_bit({p, " rstn"}, cluster_rstn, v.rstn);
      check_bit({p, " fetch"}, cluster_fetch_enable, v.fetch);
      check_bit({p, " on"}, cluster_on, v.on);
      check_bit({p, " done"}, seq_done, v.done);
      check_bit({p, " byp"}, cluster_byp, v.byp);
      check_word({p, " boot"}, cluster_boot_addr, v.boot_out);
   endtask

   task automatic check_model(int cyc);
      logic          on_like;
      logic          e_pow, e_clk, e_byp;
      string         p;
      on_like = (m_phase == M_ON) || (m_phase == M_DRAIN);
      e_pow   = (m_phase != M_OFF) && !((m_phase == M_DOWN) && (m_age > H));
      e_clk   = ((m_phase == M_UP) && (m_age >= S)) || on_like ||
                ((m_phase == M_DOWN) && (m_age < H));
      e_byp   = ((m_phase == M_OFF) || (m_phase == M_UP) ||
                 ((m_phase == M_DOWN) && (m_age > H))) ? 1'b1 : m_tm;
      p = $sformatf("rand%0d", cyc);
      check_bit({p, " pow"}, cluster_pow, e_pow);
      check_bit({p, " clk_en"}, cluster_clk_en, e_clk);
      check_bit({p, " iso"}, cluster_iso, !on_like);
      check_bit({p, " rstn"}, cluster_rstn, on_like);
      check_bit({p, " fetch"}, cluster_fetch_enable, (m_phase == M_ON) && m_fetch);
      check_bit({p, " on"}, cluster_on, m_phase == M_ON);
      check_bit({p, " done"}, seq_done, m_done);
      check_bit({p, " byp"}, cluster_byp, e_byp);
      check_word({p, " boot"}, cluster_boot_addr, m_boot);
   endtask

   task automatic check_off_values(string p);
      check_bit({p, " pow"}, cluster_pow, 1'b0);
      check_bit({p, " clk_en"}, cluster_clk_en, 1'b0);
      check_bit({p, " iso"}, cluster_iso, 1'b1);
      check_bit({p, " rstn"}, cluster_rstn, 1'b0);
      check_bit({p, " done"}, seq_done, 1'b0);
      check_bit({p, " on"}, cluster_on, 1'b0);
      check_bit({p, " byp"}, cluster_byp, 1'b1);
   endtask

   localparam logic [AW-1:0] BOOT_A = 64'h0000_0000_1C00_8080;
   localparam logic [AW-1:0] BOOT_B = 64'hDEAD_BEEF_0000_1234;

   initial begin
      int waited;
      rst = 1'b0; test_mode = 1'b0; pwr_on_req = 1'b0; fetch_en_req = 1'b0;
      boot_addr = '0; cluster_busy = 1'b0;

      //       cyc req fen bsy tm  boot_in  pow clk iso rstn fch on  dn  byp boot_out
      vecs.push_back(mk( 1, 1, 0, 0, 0, BOOT_A, 1, 0, 1, 0, 0, 0, 0, 1, '0));
      vecs.push_back(mk(15, 1, 0, 0, 0, BOOT_A, 1, 0, 1, 0, 0, 0, 0, 1, '0));
      vecs.push_back(mk( 1, 1, 0, 0, 0, BOOT_A, 1, 1, 1, 0, 0, 0, 0, 1, '0));
      vecs.push_back(mk( 7, 1, 0, 0, 0, BOOT_A, 1, 1, 1, 0, 0, 0, 0, 1, '0));
      vecs.push_back(mk( 1, 1, 0, 0, 0, BOOT_A, 1, 1, 0, 1, 0, 1, 1, 0, BOOT_A));
      vecs.push_back(mk( 1, 1, 1, 0, 0, BOOT_B, 1, 1, 0, 1, 1, 1, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 1, 0, 0, 0, BOOT_B, 1, 1, 0, 1, 0, 1, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 1, 1, 0, 1, BOOT_B, 1, 1, 0, 1, 1, 1, 0, 1, BOOT_A));
      vecs.push_back(mk( 1, 1, 1, 0, 0, BOOT_B, 1, 1, 0, 1, 1, 1, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 0, 1, 1, 0, BOOT_B, 1, 1, 0, 1, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 9, 0, 1, 1, 0, BOOT_B, 1, 1, 0, 1, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 1, 1, 0, 1, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 1, 1, 1, 0, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 7, 0, 0, 0, 0, BOOT_B, 1, 1, 1, 0, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 1, 0, 1, 0, 0, 0, 0, 0, BOOT_A));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 0, 0, 1, 0, 0, 0, 0, 1, BOOT_A));
      vecs.push_back(mk(15, 0, 0, 0, 0, BOOT_B, 0, 0, 1, 0, 0, 0, 0, 1, BOOT_A));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 0, 0, 1, 0, 0, 0, 1, 1, '0));
      vecs.push_back(mk( 1, 0, 0, 0, 0, BOOT_B, 0, 0, 1, 0, 0, 0, 0, 1, '0));

      #2 rst = 1'b1;
      #1;
      check_off_values("reset");
      check_bit("reset fetch", cluster_fetch_enable, 1'b0);
      check_word("reset boot", cluster_boot_addr, '0);
      @(negedge clk) rst = 1'b0;
      tick();
      check_off_values("idle");

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus(vecs[i]);
         check_output(vecs[i], i);
      end

      // DFT in OFF keeps bypass high and changes nothing else
      test_mode = 1'b1;
      tick();
      check_off_values("dft_off");
      test_mode = 1'b0;

      // Request dropped during PWR_UP: sequence still completes, then drains
      pwr_on_req = 1'b1;
      boot_addr  = BOOT_A;
      repeat (3) tick();
      pwr_on_req = 1'b0;
      waited = 0;
      while (!cluster_on && waited < 60) begin
         tick();
         waited++;
      end
      check_bit("noabort reached_on", cluster_on, 1'b1);
      total++;
      if (waited != UP_LEN - 2) begin
         bad++;
         $display("[TB] FAIL noabort on_latency actual=%0d required=%0d", waited + 3, UP_LEN + 1);
      end
      check_bit("noabort done", seq_done, 1'b1);
      tick();
      check_bit("noabort drain on", cluster_on, 1'b0);
      check_bit("noabort drain rstn", cluster_rstn, 1'b1);
      waited = 0;
      while (!seq_done && waited < 80) begin
         tick();
         waited++;
      end
      check_bit("noabort off_done", seq_done, 1'b1);
      check_bit("noabort off_pow", cluster_pow, 1'b0);

      // Reset while in CLK_UP: outputs fall back at once, no done pulse
      pwr_on_req = 1'b1;
      repeat (UP_LEN - 6) tick();
      check_bit("midrst pre clk_en", cluster_clk_en, 1'b1);
      check_bit("midrst pre pow", cluster_pow, 1'b1);
      #1 rst = 1'b1;
      #1;
      check_off_values("midrst");
      pwr_on_req = 1'b0;
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_bit("midrst after done", seq_done, 1'b0);
         check_bit("midrst after pow", cluster_pow, 1'b0);
      end

      // Random stimulus against the reference model
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if ($urandom_range(0, 39) == 0) pwr_on_req = ~pwr_on_req;
         if ($urandom_range(0, 29) == 0) test_mode = ~test_mode;
         fetch_en_req = 1'($urandom_range(0, 1));
         cluster_busy = ($urandom_range(0, 2) == 0);
         boot_addr    = {$urandom, $urandom};
         if ($urandom_range(0, 799) == 0) begin
            rst = 1'b1;
            #1 rst = 1'b0;
         end
         tick();
         check_model(cyc);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
